// File: rtl/calu_seq_if.sv
// Handshake bus for the sequential complex ALU: an operation request goes in
// and a {real, imag} result with its flags comes back out.
interface calu_seq_if #(
   parameter int W   = 16,
   parameter int OPW = 4
);
   logic             in_valid;
   logic             in_ready;
   logic [OPW-1:0]   opcode;
   logic [2*W-1:0]   z1;
   logic [2*W-1:0]   z2;
   logic             out_valid;
   logic             out_ready;
   logic [2*W-1:0]   zout;
   logic [12:0]      flags;

   modport master (output in_valid, opcode, z1, z2, out_ready,
                   input  in_ready, out_valid, zout, flags);
   modport slave  (input  in_valid, opcode, z1, z2, out_ready,
                   output in_ready, out_valid, zout, flags);
endinterface

// File: rtl/calu_seq.sv
// calu_seq: multi-cycle complex ALU on packed {real, imag} W-bit operands.
// Add/sub/inc/dec/swap/conj/logic finish in EXEC. Multiply registers the
// partial products and sums them in MUL2. Divide runs a restoring divider on
// the real and imag magnitudes in parallel.
// Optional macro CALU_MAG_EN adds CMAG (opcode 1000) using an iterative
// restoring square root; without it, opcode 1000 is illegal.
// flags = {ILL, CR, CI, OR, OI, ZR, ZI, NR, NI, DVFR, DVFI, ZER, ZEI}
module calu_seq #(
   parameter int W   = 16,
   parameter int OPW = 4
) (
   input  logic      clk,
   input  logic      rst_n,
   calu_seq_if.slave bus
);
   localparam int N  = 2*W + 1;          // numerator / quotient width
   localparam int CW = $clog2(N + 1);

   localparam logic [OPW-1:0] OP_ADD  = OPW'(4'h0);
   localparam logic [OPW-1:0] OP_SUB  = OPW'(4'h1);
   localparam logic [OPW-1:0] OP_MUL  = OPW'(4'h2);
   localparam logic [OPW-1:0] OP_DIV  = OPW'(4'h3);
   localparam logic [OPW-1:0] OP_INC  = OPW'(4'h4);
   localparam logic [OPW-1:0] OP_DEC  = OPW'(4'h5);
   localparam logic [OPW-1:0] OP_SWAP = OPW'(4'h6);
   localparam logic [OPW-1:0] OP_CONJ = OPW'(4'h7);
   localparam logic [OPW-1:0] OP_AND  = OPW'(4'h9);
   localparam logic [OPW-1:0] OP_OR   = OPW'(4'hA);
   localparam logic [OPW-1:0] OP_XOR  = OPW'(4'hB);
   localparam logic [OPW-1:0] OP_XNOR = OPW'(4'hC);
`ifdef CALU_MAG_EN
   localparam logic [OPW-1:0] OP_MAG  = OPW'(4'h8);
`endif

   // largest positive W-bit value and magnitude of the most negative one
   localparam logic [N-1:0] MAXP = {{(N-W+1){1'b0}}, {(W-1){1'b1}}};
   localparam logic [N-1:0] MINM = {{(N-W){1'b0}}, 1'b1, {(W-1){1'b0}}};

   typedef enum logic [2:0] {S_IDLE, S_EXEC, S_MUL2, S_DIV, S_SQRT, S_DONE} state_t;

   state_t                state_q, state_d;
   logic [OPW-1:0]        op_q, op_d;
   logic [2*W-1:0]        z1_q, z1_d, z2_q, z2_d;
   logic                  in_ready_q, in_ready_d;
   logic                  out_valid_q, out_valid_d;
   logic [2*W-1:0]        zout_q, zout_d;
   logic [12:0]           flags_q, flags_d;
   logic [2*W-1:0]        p_ac_q, p_ac_d, p_bd_q, p_bd_d, p_ad_q, p_ad_d, p_bc_q, p_bc_d;
   logic [N-1:0]          num_r_q, num_r_d, num_i_q, num_i_d, den_q, den_d;
   logic [N-1:0]          dr_r_q, dr_r_d, dr_i_q, dr_i_d;   // partial remainders
   logic [N-1:0]          dq_r_q, dq_r_d, dq_i_q, dq_i_d;   // dividend in, quotient out
   logic [CW-1:0]         cnt_q, cnt_d;

   // {carry, signed overflow, sum} of x + y + ci
   function automatic logic [W+1:0] add_f(input logic [W-1:0] x, input logic [W-1:0] y,
                                          input logic ci);
      logic [W:0] s;
      s = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
      return {s[W], (x[W-1] == y[W-1]) && (s[W-1] != x[W-1]), s[W-1:0]};
   endfunction

   function automatic logic [12:0] pack_flags(input logic cr, input logic ci,
                                              input logic ovr, input logic ovi,
                                              input logic dvr, input logic dvi,
                                              input logic [W-1:0] re, input logic [W-1:0] im);
      return {1'b0, cr, ci, ovr, ovi, re == '0, im == '0, re[W-1], im[W-1], dvr, dvi, 2'b00};
   endfunction

   function automatic logic [N-1:0] sx(input logic [2*W-1:0] v);
      return {v[2*W-1], v};
   endfunction

   function automatic logic [N-1:0] abs_n(input logic [N-1:0] v);
      return v[N-1] ? (~v + 1'b1) : v;
   endfunction

   // bits above the W-bit result are pure sign extension
   function automatic logic fits_w(input logic [N-W:0] hi);
      return (&hi) | ~(|hi);
   endfunction

   // one restoring step: returns {remainder, quotient/dividend shift reg}
   function automatic logic [2*N-1:0] div_step(input logic [N-1:0] rem, input logic [N-1:0] quo,
                                               input logic [N-1:0] den);
      logic [N:0] r;
      r = {rem, quo[N-1]};
      if (r >= {1'b0, den}) return {r[N-1:0] - den, quo[N-2:0], 1'b1};
      else                  return {r[N-1:0], quo[N-2:0], 1'b0};
   endfunction

   // apply quotient sign and saturate: {dvf, value}
   function automatic logic [W:0] div_fin(input logic neg, input logic [N-1:0] mag);
      logic [W-1:0] v;
      if (!neg && mag > MAXP) return {1'b1, 1'b0, {(W-1){1'b1}}};
      if (neg && mag > MINM)  return {1'b1, 1'b1, {(W-1){1'b0}}};
      v = mag[W-1:0];
      return {1'b0, neg ? (~v + 1'b1) : v};
   endfunction

   logic signed [W-1:0]   a, b, c, d;
   logic signed [2*W-1:0] ac, bd, ad, bc, cc, dd;
   logic [N-1:0]          num_r, num_i, den, mre, mim;
   logic [2*N-1:0]        st_r, st_i;
   logic [W:0]            fin_r, fin_i;

   assign a  = z1_q[2*W-1:W];
   assign b  = z1_q[W-1:0];
   assign c  = z2_q[2*W-1:W];
   assign d  = z2_q[W-1:0];
   assign ac = a * c;
   assign bd = b * d;
   assign ad = a * d;
   assign bc = b * c;
   assign cc = c * c;
   assign dd = d * d;
   assign num_r = sx(ac) + sx(bd);
   assign num_i = sx(bc) - sx(ad);
   assign den   = {1'b0, cc} + {1'b0, dd};
   assign mre   = sx(p_ac_q) - sx(p_bd_q);
   assign mim   = sx(p_ad_q) + sx(p_bc_q);
   assign st_r  = div_step(dr_r_q, dq_r_q, den_q);
   assign st_i  = div_step(dr_i_q, dq_i_q, den_q);
   assign fin_r = div_fin(num_r_q[N-1], st_r[N-1:0]);
   assign fin_i = div_fin(num_i_q[N-1], st_i[N-1:0]);

`ifdef CALU_MAG_EN
   logic signed [2*W-1:0] aa, bb;
   logic [2*W+1:0]        sq_rad_q, sq_rad_d, sq_rad_n;
   logic [W+2:0]          sq_rem_q, sq_rem_d, sq_rem_n;
   logic [W:0]            sq_root_q, sq_root_d, sq_root_n;
   logic [W+4:0]          sq_r, sq_t;
   logic                  sq_sat;
   logic [W-1:0]          sq_res;

   assign aa = a * a;
   assign bb = b * b;

   // one restoring square-root step: two radicand bits in, one root bit out
   always_comb begin
      sq_r     = {sq_rem_q, sq_rad_q[2*W+1:2*W]};
      sq_t     = {2'b00, sq_root_q, 2'b01};
      sq_rad_n = {sq_rad_q[2*W-1:0], 2'b00};
      if (sq_r >= sq_t) begin
         sq_rem_n  = sq_r[W+2:0] - sq_t[W+2:0];
         sq_root_n = {sq_root_q[W-1:0], 1'b1};
      end else begin
         sq_rem_n  = sq_r[W+2:0];
         sq_root_n = {sq_root_q[W-1:0], 1'b0};
      end
      sq_sat = sq_root_n > {2'b00, {(W-1){1'b1}}};
      sq_res = sq_sat ? {1'b0, {(W-1){1'b1}}} : sq_root_n[W-1:0];
   end
`endif

   // single-cycle ops: add/sub/inc/dec via one adder form, swap/conj/bitwise
   logic [W+1:0]   s_r, s_i;
   logic [W-1:0]   re1, im1;
   logic           ill1, arith1;
   logic [2*W-1:0] r1_zout;
   logic [12:0]    r1_flags;

   always_comb begin
      s_r = '0; s_i = '0; re1 = '0; im1 = '0; ill1 = 1'b0; arith1 = 1'b0;
      case (op_q)
         OP_ADD:  begin s_r = add_f(a, c, 1'b0);   s_i = add_f(b, d, 1'b0);   arith1 = 1'b1; end
         OP_SUB:  begin s_r = add_f(a, ~c, 1'b1);  s_i = add_f(b, ~d, 1'b1);  arith1 = 1'b1; end
         OP_INC:  begin s_r = add_f(a, '0, 1'b1);  s_i = add_f(b, '0, 1'b1);  arith1 = 1'b1; end
         OP_DEC:  begin s_r = add_f(a, '1, 1'b0);  s_i = add_f(b, '1, 1'b0);  arith1 = 1'b1; end
         OP_SWAP: begin re1 = b;       im1 = a;        end
         OP_CONJ: begin re1 = a;       im1 = -b;       end
         OP_AND:  begin re1 = a & c;   im1 = b & d;    end
         OP_OR:   begin re1 = a | c;   im1 = b | d;    end
         OP_XOR:  begin re1 = a ^ c;   im1 = b ^ d;    end
         OP_XNOR: begin re1 = ~(a ^ c); im1 = ~(b ^ d); end
         default: ill1 = 1'b1;
      endcase
      if (arith1) begin
         re1 = s_r[W-1:0];
         im1 = s_i[W-1:0];
      end
      r1_zout  = {re1, im1};
      r1_flags = ill1 ? 13'h1000
                      : pack_flags(s_r[W+1], s_i[W+1], s_r[W], s_i[W], 1'b0, 1'b0, re1, im1);
   end

   // sequencer next-state: accept, dispatch, iterate, hold result until taken
   always_comb begin
      state_d = state_q; op_d = op_q; z1_d = z1_q; z2_d = z2_q;
      in_ready_d = in_ready_q; out_valid_d = out_valid_q;
      zout_d = zout_q; flags_d = flags_q;
      p_ac_d = p_ac_q; p_bd_d = p_bd_q; p_ad_d = p_ad_q; p_bc_d = p_bc_q;
      num_r_d = num_r_q; num_i_d = num_i_q; den_d = den_q;
      dr_r_d = dr_r_q; dr_i_d = dr_i_q; dq_r_d = dq_r_q; dq_i_d = dq_i_q;
      cnt_d = cnt_q;
`ifdef CALU_MAG_EN
      sq_rad_d = sq_rad_q; sq_rem_d = sq_rem_q; sq_root_d = sq_root_q;
`endif
      case (state_q)
         S_IDLE: if (bus.in_valid && in_ready_q) begin
            op_d = bus.opcode; z1_d = bus.z1; z2_d = bus.z2;
            in_ready_d = 1'b0;
            state_d = S_EXEC;
         end
         S_EXEC: begin
            cnt_d = '0;
            case (op_q)
               OP_MUL: begin
                  p_ac_d = ac; p_bd_d = bd; p_ad_d = ad; p_bc_d = bc;
                  state_d = S_MUL2;
               end
               OP_DIV: begin
                  if (c == '0 && d == '0) begin
                     zout_d = '0;
                     flags_d = pack_flags(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0) | 13'h0003;
                     out_valid_d = 1'b1;
                     state_d = S_DONE;
                  end else begin
                     num_r_d = num_r; num_i_d = num_i; den_d = den;
                     state_d = S_DIV;
                  end
               end
`ifdef CALU_MAG_EN
               OP_MAG: begin
                  p_ac_d = aa; p_bd_d = bb;
                  state_d = S_SQRT;
               end
`endif
               default: begin
                  zout_d = r1_zout; flags_d = r1_flags;
                  out_valid_d = 1'b1;
                  state_d = S_DONE;
               end
            endcase
         end
         S_MUL2: begin
            zout_d  = {mre[W-1:0], mim[W-1:0]};
            flags_d = pack_flags(1'b0, 1'b0, ~fits_w(mre[N-1:W-1]), ~fits_w(mim[N-1:W-1]),
                                 1'b0, 1'b0, mre[W-1:0], mim[W-1:0]);
            out_valid_d = 1'b1;
            state_d = S_DONE;
         end
         S_DIV: begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == '0) begin
               // first cycle loads magnitudes; the sign is reapplied on exit
               dr_r_d = '0; dr_i_d = '0;
               dq_r_d = abs_n(num_r_q); dq_i_d = abs_n(num_i_q);
            end else begin
               dr_r_d = st_r[2*N-1:N]; dq_r_d = st_r[N-1:0];
               dr_i_d = st_i[2*N-1:N]; dq_i_d = st_i[N-1:0];
               if (cnt_q == CW'(N)) begin
                  zout_d  = {fin_r[W-1:0], fin_i[W-1:0]};
                  flags_d = pack_flags(1'b0, 1'b0, 1'b0, 1'b0, fin_r[W], fin_i[W],
                                       fin_r[W-1:0], fin_i[W-1:0]);
                  out_valid_d = 1'b1;
                  state_d = S_DONE;
               end
            end
         end
`ifdef CALU_MAG_EN
         S_SQRT: begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == '0) begin
               sq_rad_d  = {2'b00, p_ac_q + p_bd_q};
               sq_rem_d  = '0;
               sq_root_d = '0;
            end else begin
               sq_rad_d = sq_rad_n; sq_rem_d = sq_rem_n; sq_root_d = sq_root_n;
               if (cnt_q == CW'(W+1)) begin
                  zout_d  = {sq_res, {W{1'b0}}};
                  flags_d = pack_flags(1'b0, 1'b0, sq_sat, 1'b0, 1'b0, 1'b0, sq_res, '0);
                  out_valid_d = 1'b1;
                  state_d = S_DONE;
               end
            end
         end
`endif
         S_DONE: if (bus.out_ready) begin
            out_valid_d = 1'b0;
            in_ready_d  = 1'b1;
            state_d     = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // state and registered outputs; reset aborts any operation in flight
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE; op_q <= '0; z1_q <= '0; z2_q <= '0;
         in_ready_q <= 1'b1; out_valid_q <= 1'b0; zout_q <= '0; flags_q <= '0;
         p_ac_q <= '0; p_bd_q <= '0; p_ad_q <= '0; p_bc_q <= '0;
         num_r_q <= '0; num_i_q <= '0; den_q <= '0;
         dr_r_q <= '0; dr_i_q <= '0; dq_r_q <= '0; dq_i_q <= '0; cnt_q <= '0;
`ifdef CALU_MAG_EN
         sq_rad_q <= '0; sq_rem_q <= '0; sq_root_q <= '0;
`endif
      end else begin
         state_q <= state_d; op_q <= op_d; z1_q <= z1_d; z2_q <= z2_d;
         in_ready_q <= in_ready_d; out_valid_q <= out_valid_d; zout_q <= zout_d; flags_q <= flags_d;
         p_ac_q <= p_ac_d; p_bd_q <= p_bd_d; p_ad_q <= p_ad_d; p_bc_q <= p_bc_d;
         num_r_q <= num_r_d; num_i_q <= num_i_d; den_q <= den_d;
         dr_r_q <= dr_r_d; dr_i_q <= dr_i_d; dq_r_q <= dq_r_d; dq_i_q <= dq_i_d; cnt_q <= cnt_d;
`ifdef CALU_MAG_EN
         sq_rad_q <= sq_rad_d; sq_rem_q <= sq_rem_d; sq_root_q <= sq_root_d;
`endif
      end
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = out_valid_q;
   assign bus.zout      = zout_q;
   assign bus.flags     = flags_q;
endmodule

// File: tb/tb_calu_seq.sv
// Directed bench for calu_seq (W=16). Latency is counted with the accept
// cycle as cycle 1, so a result registered one edge after accept is latency 2.
module tb_calu_seq;
   localparam int W = 16;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_chk = 0;
   int   n_fail = 0;

   calu_seq_if #(.W(W), .OPW(4)) bus ();
   calu_seq #(.W(W), .OPW(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // issue one op, wait (bounded) for out_valid, check latency/zout/flags
   task automatic run(input string tag, input logic [3:0] op, input logic [31:0] a,
                      input logic [31:0] b, input logic [31:0] ez, input logic [12:0] ef,
                      input int elat);
      int lat;
      @(negedge clk);
      bus.in_valid = 1'b1; bus.opcode = op; bus.z1 = a; bus.z2 = b;
      @(posedge clk);
      lat = 1;
      #1 bus.in_valid = 1'b0;
      while (!bus.out_valid && lat < 200) begin
         @(posedge clk);
         lat++;
         #1;
      end
      chk({tag, " lat"},   64'(lat),       64'(elat));
      chk({tag, " zout"},  64'(bus.zout),  64'(ez));
      chk({tag, " flags"}, 64'(bus.flags), 64'(ef));
   endtask

   task automatic consume(input string tag);
      @(negedge clk);
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1 bus.out_ready = 1'b0;
      chk({tag, " in_ready after take"}, 64'(bus.in_ready), 64'd1);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      bus.in_valid = 1'b0; bus.opcode = '0; bus.z1 = '0; bus.z2 = '0; bus.out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst in_ready",  64'(bus.in_ready),  64'd1);
      chk("rst out_valid", 64'(bus.out_valid), 64'd0);
      chk("rst zout",      64'(bus.zout),      64'd0);
      chk("rst flags",     64'(bus.flags),     64'd0);
      @(negedge clk) rst_n = 1'b1;

      run("cadd", 4'b0000, 32'h0003_0004, 32'h0001_FFFE, 32'h0004_0002, 13'h0400, 2);
      consume("cadd");
      run("cmul", 4'b0010, 32'h0003_0004, 32'h0001_0002, 32'hFFFB_000A, 13'h0020, 3);
      consume("cmul");
      run("cmul ovf", 4'b0010, 32'h0100_0000, 32'h0100_0000, 32'h0000_0000, 13'h02C0, 3);
      consume("cmul ovf");
      run("cdiv", 4'b0011, 32'h000A_0005, 32'h0001_0002, 32'h0004_FFFD, 13'h0010, 36);
      consume("cdiv");
      run("cdiv sat", 4'b0011, 32'h8000_0000, 32'hFFFF_0000, 32'h7FFF_0000, 13'h0048, 36);
      consume("cdiv sat");
      run("cdiv zero", 4'b0011, 32'h0005_0003, 32'h0000_0000, 32'h0000_0000, 13'h00C3, 2);
      consume("cdiv zero");
      run("csub", 4'b0001, 32'h0005_0000, 32'h0003_0001, 32'h0002_FFFF, 13'h0810, 2);
      consume("csub");
      run("cinc", 4'b0100, 32'h7FFF_FFFF, 32'h0, 32'h8000_0000, 13'h0660, 2);
      consume("cinc");
      run("cdec", 4'b0101, 32'h8000_0000, 32'h0, 32'h7FFF_FFFF, 13'h0A10, 2);
      consume("cdec");
      run("cswap", 4'b0110, 32'h1234_8000, 32'h0, 32'h8000_1234, 13'h0020, 2);
      consume("cswap");
      run("cconj", 4'b0111, 32'h0001_0005, 32'h0, 32'h0001_FFFB, 13'h0010, 2);
      consume("cconj");
      run("and", 4'b1001, 32'h00F0_FF00, 32'h0FF0_0F00, 32'h00F0_0F00, 13'h0000, 2);
      consume("and");
      run("xor", 4'b1011, 32'hF0F0_00FF, 32'h0F0F_00FF, 32'hFFFF_0000, 13'h0060, 2);
      consume("xor");
      run("ill", 4'b1111, 32'h1234_5678, 32'h1111_2222, 32'h0000_0000, 13'h1000, 2);
      consume("ill");
`ifdef CALU_MAG_EN
      run("cmag", 4'b1000, 32'h0003_0004, 32'h0, 32'h0005_0000, 13'h0040, 20);
`else
      run("op1000 ill", 4'b1000, 32'h0003_0004, 32'h0, 32'h0000_0000, 13'h1000, 2);
`endif
      consume("op1000");

      // result held while the consumer stalls
      run("cadd ovf", 4'b0000, 32'h7FFF_0000, 32'h0001_0000, 32'h8000_0000, 13'h0260, 2);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("hold {ov,ir,flags,zout}", {17'd0, bus.out_valid, bus.in_ready, bus.flags, bus.zout},
             {17'd0, 1'b1, 1'b0, 13'h0260, 32'h8000_0000});
      end
      consume("cadd ovf");
      chk("out_valid after take", 64'(bus.out_valid), 64'd0);

      // reset while a divide is in flight
      @(negedge clk);
      bus.in_valid = 1'b1; bus.opcode = 4'b0011; bus.z1 = 32'h000A_0005; bus.z2 = 32'h0001_0002;
      @(posedge clk);
      #1 bus.in_valid = 1'b0;
      repeat (9) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("midrst out_valid", 64'(bus.out_valid), 64'd0);
      chk("midrst in_ready",  64'(bus.in_ready),  64'd1);
      @(negedge clk) rst_n = 1'b1;
      repeat (40) @(posedge clk);
      #1;
      chk("midrst no result", 64'(bus.out_valid), 64'd0);

      $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
      $finish;
   end
endmodule
